// File: rtl/esp32_boot_sequencer_pkg.sv
// Shared definitions for the ESP32 boot sequencer.
//   boot_state_e : FSM state encoding, also exported on state_o for LEDs/debug
//   PAIR_*       : synchronized {dtr, rts} pair values with a defined meaning
package esp32_boot_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_RESET = 2'd1,
      ST_STRAP = 2'd2,
      ST_HOLD  = 2'd3
   } boot_state_e;

   // Host asks for EN low.
   localparam logic [1:0] PAIR_RESET = 2'b10;
   // Host asks for GPIO0 low (bootloader entry) once EN is released.
   localparam logic [1:0] PAIR_BOOT  = 2'b01;

endpackage

// File: rtl/esp32_boot_sequencer_if.sv
// Pin bundle between the FTDI/button side and the ESP32 strap/EN pad drivers.
//   ftdi_ndtr, ftdi_nrts, force_boot : asynchronous requests into the sequencer
//   wifi_en, wifi_gpio0, strap_oe    : registered pad controls out of the sequencer
//   boot_active, state_o             : status for LEDs/debug
// Signalling: there is no valid/ready handshake on this bundle. Every input is
// a level that is synchronized and sampled each clock; every output is a level
// that holds until the state register changes.
interface esp32_boot_sequencer_if;
   logic       ftdi_ndtr;
   logic       ftdi_nrts;
   logic       force_boot;
   logic       wifi_en;
   logic       wifi_gpio0;
   logic       strap_oe;
   logic       boot_active;
   logic [1:0] state_o;

   // Requesting side (FTDI pins, button, or a testbench).
   modport master (
      output ftdi_ndtr, ftdi_nrts, force_boot,
      input  wifi_en, wifi_gpio0, strap_oe, boot_active, state_o
   );

   // The sequencer itself.
   modport slave (
      input  ftdi_ndtr, ftdi_nrts, force_boot,
      output wifi_en, wifi_gpio0, strap_oe, boot_active, state_o
   );
endinterface

// File: rtl/esp32_boot_sequencer_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level.
//   clk_25mhz : destination clock
//   d_i       : asynchronous input
//   q_o       : synchronized output (2 cycles of latency)
// No reset: the chain flushes within two clocks of any input level.
module sync_2ff (
   input  logic clk_25mhz,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_25mhz) begin
      meta_q <= d_i;
      sync_q <= meta_q;
   end

   assign q_o = sync_q;

endmodule

// File: rtl/esp32_boot_sequencer.sv
// ESP32 reset / boot-mode sequencer for the ULX3S.
//   clk_25mhz : sole clock
//   resetn    : synchronous, active-low reset
//   bus       : slave side of esp32_boot_sequencer_if (FTDI DTR/RTS, force_boot
//               in; wifi_en, wifi_gpio0, strap_oe, boot_active, state_o out)
// Enforces a minimum EN-low time, drives GPIO0 low while EN rises, then keeps
// the shared SD strap pins driven for 2^C_hold_bits cycles after release.
module esp32_boot_sequencer
   import esp32_boot_pkg::*;
#(
   parameter int C_en_low_cycles = 2500,
   parameter int C_hold_bits     = 17
) (
   input logic                    clk_25mhz,
   input logic                    resetn,
   esp32_boot_sequencer_if.slave  bus
);

   localparam int CW = C_hold_bits + 1;
   localparam logic [CW-1:0] CNT_EN_LAST   = CW'(C_en_low_cycles - 1);
   // Last count of the hold window: the next increment would set the top bit.
   localparam logic [CW-1:0] CNT_HOLD_LAST = {1'b0, {C_hold_bits{1'b1}}};

   logic        dtr_s, rts_s, force_s;
   logic [1:0]  pair;
   logic        force_rise;

   boot_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic        auto_q, auto_d;
   logic        force_prev_q;
   logic        en_q, gpio0_q, oe_q, active_q;

   sync_2ff u_sync_dtr   (.clk_25mhz(clk_25mhz), .d_i(bus.ftdi_ndtr),  .q_o(dtr_s));
   sync_2ff u_sync_rts   (.clk_25mhz(clk_25mhz), .d_i(bus.ftdi_nrts),  .q_o(rts_s));
   sync_2ff u_sync_force (.clk_25mhz(clk_25mhz), .d_i(bus.force_boot), .q_o(force_s));

   assign pair       = {dtr_s, rts_s};
   assign force_rise = force_s & ~force_prev_q;

   always_comb begin
      state_d = state_q;
      auto_d  = auto_q;
      case (state_q)
         ST_RUN: begin
            // Host request beats a simultaneous button edge.
            if (pair == PAIR_RESET) begin
               state_d = ST_RESET;
               auto_d  = 1'b0;
            end else if (force_rise) begin
               state_d = ST_RESET;
               auto_d  = 1'b1;
            end
         end
         ST_RESET: begin
            // EN stays low for at least C_en_low_cycles even if the host lets go early.
            if (cnt_q >= CNT_EN_LAST) begin
               if (auto_q || (pair == PAIR_BOOT)) state_d = ST_STRAP;
               else if (pair != PAIR_RESET)       state_d = ST_RUN;
            end
         end
         ST_STRAP: begin
            if (pair == PAIR_RESET) begin
               state_d = ST_RESET;
               auto_d  = 1'b0;
            end else if (auto_q ? (cnt_q == CNT_EN_LAST) : (pair != PAIR_BOOT)) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (pair == PAIR_RESET) begin
               state_d = ST_RESET;
               auto_d  = 1'b0;
            end else if (cnt_q == CNT_HOLD_LAST) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Counter restarts on every state entry; it parks at the minimum EN-low
      // count in RESET so a long host pulse cannot wrap it.
      if (state_d != state_q)
         cnt_d = '0;
      else if ((state_q == ST_RESET) && (cnt_q >= CNT_EN_LAST))
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk_25mhz) begin
      if (!resetn) begin
         state_q      <= ST_RUN;
         cnt_q        <= '0;
         auto_q       <= 1'b0;
         force_prev_q <= 1'b0;
         en_q         <= 1'b1;
         gpio0_q      <= 1'b1;
         oe_q         <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         auto_q       <= auto_d;
         force_prev_q <= force_s;
         // Output flops load the decode of the next state, so they always
         // match state_q and GPIO0 falls on the same edge that EN rises.
         en_q         <= (state_d != ST_RESET);
         gpio0_q      <= (state_d != ST_STRAP);
         oe_q         <= (state_d == ST_STRAP) || (state_d == ST_HOLD);
         active_q     <= (state_d != ST_RUN);
      end
   end

   assign bus.wifi_en     = en_q;
   assign bus.wifi_gpio0  = gpio0_q;
   assign bus.strap_oe    = oe_q;
   assign bus.boot_active = active_q;
   assign bus.state_o     = state_q;

endmodule
